// File: rtl/axi_config_rd_if.sv
// AXI4 read-channel bundle (AR + R) between a bus master and the
// config-space read responder.
interface axi_config_rd_if #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int ID_WIDTH    = 8,
  parameter int RUSER_WIDTH = 1
);
  // Read address channel
  logic [ID_WIDTH-1:0]    arid;
  logic [ADDR_WIDTH-1:0]  araddr;
  logic [7:0]             arlen;
  logic [2:0]             arsize;
  logic [1:0]             arburst;
  logic                   arlock;
  logic [3:0]             arcache;
  logic [2:0]             arprot;
  logic [3:0]             arqos;
  logic [3:0]             arregion;
  logic                   arvalid;
  logic                   arready;

  // Read data channel
  logic [ID_WIDTH-1:0]    rid;
  logic [DATA_WIDTH-1:0]  rdata;
  logic [1:0]             rresp;
  logic                   rlast;
  logic [RUSER_WIDTH-1:0] ruser;
  logic                   rvalid;
  logic                   rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
           arqos, arregion, arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, ruser, rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
           arqos, arregion, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, ruser, rvalid
  );
endinterface

// File: rtl/axi_config_rd.sv
// AXI4 read responder for the config register space. Each burst beat
// becomes one single-cycle rd strobe; the returned word (or a timeout
// SLVERR) is handed back as an R beat. One burst in flight at a time.
module axi_config_rd #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STRB_WIDTH   = DATA_WIDTH / 8,
  parameter int ID_WIDTH     = 8,
  parameter int RUSER_ENABLE = 0,
  parameter int RUSER_WIDTH  = 1,
  parameter int TIMEOUT      = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  axi_config_rd_if.slave        s_axi,
  output logic                  rd,
  output logic [ADDR_WIDTH-1:0] raddr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  rd_valid
);

  // Counter must be able to hold TIMEOUT itself (it increments on the
  // cycle it hits the limit).
  localparam int TMO_WIDTH = $clog2(TIMEOUT + 1);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                 state_reg,   state_next;
  logic                   arready_reg, arready_next;
  logic                   rvalid_reg,  rvalid_next;
  logic                   rlast_reg,   rlast_next;
  logic                   rd_reg,      rd_next;
  logic [1:0]             rresp_reg,   rresp_next;
  logic [DATA_WIDTH-1:0]  rdata_reg,   rdata_next;
  logic [ID_WIDTH-1:0]    rid_reg,     rid_next;
  logic [ADDR_WIDTH-1:0]  raddr_reg,   raddr_next;
  logic [ID_WIDTH-1:0]    id_reg,      id_next;
  logic [ADDR_WIDTH-1:0]  addr_reg,    addr_next;
  logic [7:0]             len_reg,     len_next;
  logic                   fixed_reg,   fixed_next;
  logic [7:0]             beat_reg,    beat_next;
  logic [TMO_WIDTH-1:0]   tmo_reg,     tmo_next;
  logic [ADDR_WIDTH-1:0]  addr_adv;

  // Sideband AR fields and user-signal parameters carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{s_axi.arsize, s_axi.arlock, s_axi.arcache, s_axi.arprot,
                       s_axi.arqos, s_axi.arregion,
                       (RUSER_ENABLE != 0), (RUSER_WIDTH != 0)};

  // FIXED bursts re-read the same word; everything else steps one word,
  // wrapping silently at the top of the address space.
  assign addr_adv = fixed_reg ? addr_reg : addr_reg + ADDR_WIDTH'(STRB_WIDTH);

  // Next-state and next-output logic for the beat sequencer.
  always_comb begin
    state_next   = state_reg;
    arready_next = arready_reg;
    rvalid_next  = rvalid_reg;
    rlast_next   = rlast_reg;
    rd_next      = 1'b0;
    rresp_next   = rresp_reg;
    rdata_next   = rdata_reg;
    rid_next     = rid_reg;
    raddr_next   = raddr_reg;
    id_next      = id_reg;
    addr_next    = addr_reg;
    len_next     = len_reg;
    fixed_next   = fixed_reg;
    beat_next    = beat_reg;
    tmo_next     = tmo_reg;

    case (state_reg)
      IDLE: begin
        arready_next = 1'b1;
        if (s_axi.arvalid && arready_reg) begin
          arready_next = 1'b0;
          id_next      = s_axi.arid;
          addr_next    = s_axi.araddr;
          len_next     = s_axi.arlen;
          fixed_next   = (s_axi.arburst == 2'b00);
          beat_next    = 8'd0;
          rd_next      = 1'b1;
          raddr_next   = s_axi.araddr;
          state_next   = ISSUE;
        end
      end

      ISSUE: begin
        tmo_next   = '0;
        state_next = WAIT;
      end

      WAIT: begin
        tmo_next = tmo_reg + 1'b1;
        // rd_valid is checked first so a reply on the final cycle still wins.
        if (rd_valid) begin
          rdata_next  = rd_data;
          rresp_next  = RESP_OKAY;
          rvalid_next = 1'b1;
          rid_next    = id_reg;
          rlast_next  = (beat_reg == len_reg);
          state_next  = RESP;
        end else if (tmo_reg == TMO_WIDTH'(TIMEOUT - 1)) begin
          rdata_next  = '0;
          rresp_next  = RESP_SLVERR;
          rvalid_next = 1'b1;
          rid_next    = id_reg;
          rlast_next  = (beat_reg == len_reg);
          state_next  = RESP;
        end
      end

      RESP: begin
        if (s_axi.rready) begin
          rvalid_next = 1'b0;
          if (rlast_reg) begin
            rlast_next = 1'b0;
            state_next = IDLE;
          end else begin
            beat_next  = beat_reg + 8'd1;
            addr_next  = addr_adv;
            rd_next    = 1'b1;
            raddr_next = addr_adv;
            state_next = ISSUE;
          end
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // State and output registers; reset abandons any burst in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      arready_reg <= 1'b0;
      rvalid_reg  <= 1'b0;
      rlast_reg   <= 1'b0;
      rd_reg      <= 1'b0;
      rresp_reg   <= RESP_OKAY;
      rdata_reg   <= '0;
      rid_reg     <= '0;
      raddr_reg   <= '0;
      id_reg      <= '0;
      addr_reg    <= '0;
      len_reg     <= 8'd0;
      fixed_reg   <= 1'b0;
      beat_reg    <= 8'd0;
      tmo_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      arready_reg <= arready_next;
      rvalid_reg  <= rvalid_next;
      rlast_reg   <= rlast_next;
      rd_reg      <= rd_next;
      rresp_reg   <= rresp_next;
      rdata_reg   <= rdata_next;
      rid_reg     <= rid_next;
      raddr_reg   <= raddr_next;
      id_reg      <= id_next;
      addr_reg    <= addr_next;
      len_reg     <= len_next;
      fixed_reg   <= fixed_next;
      beat_reg    <= beat_next;
      tmo_reg     <= tmo_next;
    end
  end

  assign s_axi.arready = arready_reg;
  assign s_axi.rvalid  = rvalid_reg;
  assign s_axi.rlast   = rlast_reg;
  assign s_axi.rresp   = rresp_reg;
  assign s_axi.rdata   = rdata_reg;
  assign s_axi.rid     = rid_reg;
  assign s_axi.ruser   = '0;
  assign rd            = rd_reg;
  assign raddr         = raddr_reg;

endmodule

// File: doc/axi_config_rd.md
Name: axi_config_rd

Overview:
- AXI4 read-side responder for the config register space; the read counterpart of the config write block.
- Accepts AXI4 read bursts and issues one single-cycle `rd` strobe per beat with a word address.
- Waits for the register space to return data on `rd_valid`, then returns the data as an R beat.
- A per-beat timeout turns a missing response into SLVERR, so the bus can never hang.

Parameters:
- ADDR_WIDTH, 32, address width in bits.
- DATA_WIDTH, 32, data bus width in bits.
- STRB_WIDTH, DATA_WIDTH/8, bytes per word; also the address increment per beat.
- ID_WIDTH, 8, width of the ARID/RID signals.
- RUSER_ENABLE, 0, when 0, s_axi_ruser is driven to zero.
- RUSER_WIDTH, 1, width of the ruser signal.
- TIMEOUT, 255, maximum number of cycles to wait for rd_valid after a rd strobe; must be 1 or greater.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- s_axi_arid  in  ID_WIDTH  read ID
- s_axi_araddr  in  ADDR_WIDTH  burst start byte address
- s_axi_arlen  in  8  beats minus 1
- s_axi_arsize  in  3  ignored; full-width beats are assumed
- s_axi_arburst  in  2  00 = FIXED; any other value is treated as INCR
- s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos, s_axi_arregion  in  1/4/3/4/4  ignored
- s_axi_arvalid  in  1  AR valid
- s_axi_arready  out  1  AR ready
- s_axi_rid  out  ID_WIDTH  response ID
- s_axi_rdata  out  DATA_WIDTH  read data
- s_axi_rresp  out  2  00 = OKAY, 10 = SLVERR
- s_axi_rlast  out  1  last beat of the burst
- s_axi_ruser  out  RUSER_WIDTH  always zero
- s_axi_rvalid  out  1  R valid
- s_axi_rready  in  1  R ready
- rd  out  1  single-cycle read strobe
- raddr  out  ADDR_WIDTH  byte address; valid while rd is high
- rd_data  in  DATA_WIDTH  data from the register space
- rd_valid  in  1  rd_data is valid; earliest the cycle after the rd strobe

Behaviour:
- Reset (asynchronous) drives these values:
  - state = IDLE
  - s_axi_arready = 0, s_axi_rvalid = 0, s_axi_rlast = 0
  - rd = 0
  - s_axi_rresp = 00, s_axi_rdata = 0, s_axi_rid = 0
  - raddr = 0
  - beat counter = 0, timeout counter = 0
- All outputs are registered.
- Reset mid-burst abandons the burst. No R beat is emitted after reset deasserts. A late rd_valid is ignored because it arrives in IDLE.
- IDLE state:
  - s_axi_arready = 1.
  - On arvalid & arready, capture id, addr, len and burst; beat count = 0; deassert arready; go to ISSUE.
- ISSUE state (one cycle):
  - Drive rd = 1 for exactly this one registered cycle, with raddr = current address.
  - Clear the timeout counter; go to WAIT.
- WAIT state:
  - Timeout counter increments each cycle.
  - If rd_valid: latch rd_data, rresp = OKAY; go to RESP.
  - Else if counter reaches TIMEOUT: data = 0, rresp = SLVERR; go to RESP.
  - If rd_valid arrives in the same cycle the counter reaches TIMEOUT, rd_valid wins and the response is OKAY.
- RESP state:
  - rvalid = 1, rid = captured id, rlast = (beat count == len).
  - rdata, rresp and rlast are held stable until rready is sampled high.
  - On rvalid & rready with rlast = 1: rvalid = 0 and go to IDLE. arready rises one cycle later, so there is no back-to-back AR acceptance in the same cycle.
  - On rvalid & rready with rlast = 0: beat count + 1; advance the address; go to ISSUE.
- Address update:
  - INCR: address += STRB_WIDTH, modulo 2^ADDR_WIDTH (wraps silently at the top of the space).
  - FIXED: address is unchanged.
- Minimum latency per beat:
  - AR handshake to first rd strobe: 1 cycle.
  - rd strobe to rvalid: rd_valid latency + 1 cycle.
  - R handshake to next rd strobe: 1 cycle.
- Exactly one rd strobe is issued per beat; a stalled rready never causes re-issue.
- Only one burst is outstanding at a time.
- rd_valid outside WAIT is ignored.
- arlen = 255 gives 256 beats; the beat counter is 8 bits and does not overflow before rlast.

Test Plan:
- Single beat:
  - Stimulus: araddr = 0x100, arlen = 0, arid = 0x5A; rd_valid one cycle after rd with rd_data = 0xDEADBEEF; rready held high.
  - Required: one rd pulse with raddr = 0x100; one R beat with rdata = 0xDEADBEEF, rresp = 00, rlast = 1, rid = 0x5A.
- INCR burst with backpressure:
  - Stimulus: araddr = 0x200, arlen = 3; rready low for 3 cycles on beat 1.
  - Required: raddr = 0x200, 0x204, 0x208, 0x20C; exactly 4 rd pulses; beat 1 data held stable while stalled; rlast only on beat 4.
- FIXED burst:
  - Stimulus: araddr = 0x40, arlen = 2, arburst = 00.
  - Required: 3 rd pulses, all with raddr = 0x40.
- Timeout:
  - Stimulus: TIMEOUT = 8; rd_valid never asserted.
  - Required: rvalid 8 to 9 cycles after rd, with rresp = 10 and rdata = 0; next burst then completes with OKAY.
- Timeout race:
  - Stimulus: rd_valid asserted exactly on the TIMEOUT cycle.
  - Required: rresp = 00 with that cycle's rd_data.
- Reset mid-burst:
  - Stimulus: assert rst during WAIT of beat 2 of a 4-beat burst; pulse rd_valid after release.
  - Required: all outputs at reset values immediately (asynchronous); no R beat after release; arready = 1 one cycle after release.
